// File: rtl/page_table_walker_pkg.sv
// Shared MMU/PTW types: exception codes, walker state encoding, the PTE
// layout and the PTE classification function (also meant for a TLB fill path).
package page_table_walker_pkg;

  localparam int PTE_W = 32;
  localparam int PPN_W = PTE_W - 10;

  typedef enum logic [1:0] {
    MMU_EXC_NONE       = 2'd0,
    MMU_EXC_PAGE_FAULT = 2'd1,
    MMU_EXC_PERM_FAULT = 2'd2
  } mmu_exception_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} ptw_state_e;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [5:0]       rsvd;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
  } pte_t;

  typedef enum logic [1:0] {
    PTE_NEXT,        // pointer to next-level table
    PTE_LEAF,        // usable leaf translation
    PTE_PAGE_FAULT,
    PTE_PERM_FAULT
  } pte_class_e;

  // last_level: PTE came from the level-0 table. pfn_bits: width of a
  // physical PFN; any PPN bit above it cannot address real memory.
  function automatic pte_class_e pte_classify(pte_t pte, logic last_level,
                                              logic is_write, int pfn_bits);
    logic ppn_ovf;
    ppn_ovf = (pte.ppn >> pfn_bits) != '0;
    if (!pte.v || (pte.w && !pte.r))    return PTE_PAGE_FAULT;
    if (!pte.r && !pte.x) begin
      // pointer: the next table must exist and be addressable
      if (last_level || ppn_ovf)        return PTE_PAGE_FAULT;
      return PTE_NEXT;
    end
    // superpages are not supported: leaves only at level 0
    if (!last_level || ppn_ovf)         return PTE_PAGE_FAULT;
    if (is_write && !pte.w)             return PTE_PERM_FAULT;
    return PTE_LEAF;
  endfunction

endpackage

// File: rtl/page_table_walker.sv
// Hardware page-table walker. Accepts one VPN at a time from the MMU, reads
// one PTE per level from physical memory and returns a PFN or an exception.
// Ports:
//   clk_in, rst_n_in                      clock, async active-low reset
//   req_valid_in/req_ready_out            walk request (vpn, write, root pfn)
//   mem_req_valid_out/mem_req_ready_in    PTE read request, byte address
//   mem_resp_valid_in/mem_resp_data_in    PTE read data (no backpressure)
//   resp_valid_out/resp_ready_in          walk result: pfn + exception
module page_table_walker
  import page_table_walker_pkg::*;
#(
  parameter int PHYS_MEM_SIZE = 18,
  parameter int PAGESIZE      = 12,
  parameter int VADDR_SIZE    = 48,
  parameter int LEVELS        = 4,
  parameter int PTE_WIDTH     = 32
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              req_valid_in,
  output logic                              req_ready_out,
  input  logic [VADDR_SIZE-PAGESIZE-1:0]    req_vpn_in,
  input  logic                              req_write_in,
  input  logic [PHYS_MEM_SIZE-PAGESIZE-1:0] root_pfn_in,
  output logic                              mem_req_valid_out,
  input  logic                              mem_req_ready_in,
  output logic [PHYS_MEM_SIZE-1:0]          mem_req_addr_out,
  input  logic                              mem_resp_valid_in,
  input  logic [PTE_WIDTH-1:0]              mem_resp_data_in,
  output logic                              resp_valid_out,
  input  logic                              resp_ready_in,
  output logic [PHYS_MEM_SIZE-PAGESIZE-1:0] resp_pfn_out,
  output mmu_exception_e                    resp_exception_out
);

  localparam int VPN_W    = VADDR_SIZE - PAGESIZE;
  localparam int PFN_W    = PHYS_MEM_SIZE - PAGESIZE;
  localparam int IDX_BITS = VPN_W / LEVELS;
  localparam int LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  if (VPN_W % LEVELS != 0)          begin : g_bad_levels $error("VPN width not divisible by LEVELS"); end
  if (IDX_BITS + 2 > PAGESIZE)      begin : g_bad_idx    $error("table index does not fit in a page"); end
  if (PTE_WIDTH - 10 < PFN_W)       begin : g_bad_ppn    $error("PTE PPN field narrower than PFN"); end
  if (PTE_WIDTH != $bits(pte_t))    begin : g_bad_pte    $error("PTE_WIDTH must match pte_t"); end

  ptw_state_e     state, state_n;
  logic [LVL_W-1:0] level, level_n;
  logic [VPN_W-1:0] vpn, vpn_n;
  logic             write, write_n;
  logic [PFN_W-1:0] cur_pfn, cur_pfn_n, pfn_n;
  mmu_exception_e   exc_n;
  logic [IDX_BITS-1:0] idx;
  pte_t             pte;
  pte_class_e       cls;

  assign idx = vpn[level*IDX_BITS +: IDX_BITS];
  assign pte = pte_t'(mem_resp_data_in);
  assign cls = pte_classify(pte, level == '0, write, PFN_W);

  assign req_ready_out     = (state == IDLE);
  assign mem_req_valid_out = (state == REQ);
  assign resp_valid_out    = (state == DONE);
  assign mem_req_addr_out  = (PHYS_MEM_SIZE'(cur_pfn) << PAGESIZE) |
                             (PHYS_MEM_SIZE'(idx) << 2);

  always_comb begin
    state_n   = state;
    level_n   = level;
    vpn_n     = vpn;
    write_n   = write;
    cur_pfn_n = cur_pfn;
    pfn_n     = resp_pfn_out;
    exc_n     = resp_exception_out;
    case (state)
      IDLE: if (req_valid_in) begin
        state_n   = REQ;
        vpn_n     = req_vpn_in;
        write_n   = req_write_in;
        cur_pfn_n = root_pfn_in;
        level_n   = LVL_W'(LEVELS - 1);
      end
      REQ:  if (mem_req_ready_in) state_n = WAIT;
      WAIT: if (mem_resp_valid_in) begin
        state_n = DONE;
        pfn_n   = '0;
        case (cls)
          PTE_NEXT: begin
            state_n   = REQ;
            pfn_n     = resp_pfn_out;
            cur_pfn_n = pte.ppn[PFN_W-1:0];
            level_n   = level - 1'b1;
          end
          PTE_LEAF: begin
            pfn_n = pte.ppn[PFN_W-1:0];
            exc_n = MMU_EXC_NONE;
          end
          PTE_PERM_FAULT: exc_n = MMU_EXC_PERM_FAULT;
          default:        exc_n = MMU_EXC_PAGE_FAULT;
        endcase
      end
      DONE: if (resp_ready_in) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      level              <= '0;
      vpn                <= '0;
      write              <= 1'b0;
      cur_pfn            <= '0;
      resp_pfn_out       <= '0;
      resp_exception_out <= MMU_EXC_NONE;
    end else begin
      state              <= state_n;
      level              <= level_n;
      vpn                <= vpn_n;
      write              <= write_n;
      cur_pfn            <= cur_pfn_n;
      resp_pfn_out       <= pfn_n;
      resp_exception_out <= exc_n;
    end
  end

endmodule
